watch_adj_sched: RTL and testbench

- Schedules time-adjust requests for the watch datapath. Requests come from two sources: debounced buttons (sec/min/hour) and UART command bytes from the RX FIFO.
- Arbitrates between the two sources, serialises the requests, and emits single-cycle increment/clear pulses to the watch counters.
- Enforces a minimum gap between pulses so that counter carries settle.
- Sits between the button debouncers / UART RX FIFO and the watch counter datapath.

---
 rtl/watch_pkg.sv | 28 ++
 rtl/watch_cmd_decode.sv | 28 ++
 rtl/watch_adj_sched.sv | 182 ++++++++++++++++++
 tb/tb_watch_adj_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : watch_pkg
// Brief    : Shared codes for the watch time-adjust scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package watch_pkg;

    localparam logic [2:0] UNIT_NONE = 3'd0;
    localparam logic [2:0] UNIT_SEC  = 3'd1;
    localparam logic [2:0] UNIT_MIN  = 3'd2;
    localparam logic [2:0] UNIT_HOUR = 3'd3;
    localparam logic [2:0] UNIT_CLR  = 3'd4;

    localparam logic [7:0] CMD_SEC  = 8'h73;
    localparam logic [7:0] CMD_MIN  = 8'h6D;
    localparam logic [7:0] CMD_HOUR = 8'h68;
    localparam logic [7:0] CMD_CLR  = 8'h63;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic SRC_BTN  = 1'b0;
    localparam logic SRC_UART = 1'b1;

endpackage
`default_nettype wire

// File: rtl/watch_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module   : watch_cmd_decode
// Brief    : Maps a UART command byte to a unit code; flags unknown bytes.
// Revision : 1.0 - initial release
// ============================================================================
module watch_cmd_decode
    import watch_pkg::*;
(
    input  logic [7:0] i_data,
    output logic [2:0] o_unit,
    output logic       o_invalid
);

    always_comb begin
        o_unit    = UNIT_NONE;
        o_invalid = 1'b0;
        case (i_data)
            CMD_SEC:  o_unit = UNIT_SEC;
            CMD_MIN:  o_unit = UNIT_MIN;
            CMD_HOUR: o_unit = UNIT_HOUR;
            CMD_CLR:  o_unit = UNIT_CLR;
            default:  o_invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/watch_adj_sched.sv
`default_nettype none
// ============================================================================
// Module   : watch_adj_sched
// Brief    : Arbitrates button/UART adjust requests into spaced one-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module watch_adj_sched
    import watch_pkg::*;
#(
    parameter int unsigned GAP_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_set_mode,
    input  logic       i_btn_sec,
    input  logic       i_btn_min,
    input  logic       i_btn_hour,
    input  logic       i_cmd_valid,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ready,
    output logic       o_run_sec,
    output logic       o_run_min,
    output logic       o_run_hour,
    output logic       o_clear,
    output logic       o_cmd_err,
    output logic       o_busy
);

    localparam logic [7:0] C_GAP_LOAD = 8'(GAP_CYC);

    logic [1:0] r_state, w_state_nxt;
    logic [2:0] r_unit, w_unit_nxt;
    logic [7:0] r_gap_cnt, w_gap_nxt;
    logic [2:0] r_pend, w_pend_nxt;          // {hour, min, sec}
    logic       r_cmd_full, w_cmd_full_nxt;
    logic [2:0] r_cmd_unit, w_cmd_unit_nxt;
    logic       r_rr_ptr, w_rr_nxt;          // source preferred on contention
    logic       r_cmd_ready, w_cmd_ready_nxt;
    logic       r_run_sec, r_run_min, r_run_hour, r_clear, r_busy;
    logic       r_cmd_err, w_cmd_err_nxt;

    logic [2:0] w_dec_unit;
    logic       w_dec_invalid;
    logic [2:0] w_btn_unit;
    logic [2:0] w_btn_mask;
    logic       w_btn_has;
    logic       w_grant_uart;
    logic       w_grant_btn;
    logic       w_cmd_acc;

    watch_cmd_decode u_decode (
        .i_data    (i_cmd_data),
        .o_unit    (w_dec_unit),
        .o_invalid (w_dec_invalid)
    );

    always_comb begin
        w_btn_unit = UNIT_NONE;
        w_btn_mask = 3'b000;
        if (r_pend[2]) begin
            w_btn_unit = UNIT_HOUR;
            w_btn_mask = 3'b100;
        end else if (r_pend[1]) begin
            w_btn_unit = UNIT_MIN;
            w_btn_mask = 3'b010;
        end else if (r_pend[0]) begin
            w_btn_unit = UNIT_SEC;
            w_btn_mask = 3'b001;
        end
    end

    assign w_btn_has    = |r_pend;
    assign w_grant_uart = r_cmd_full && (!w_btn_has || (r_rr_ptr == SRC_UART));
    assign w_grant_btn  = w_btn_has && !w_grant_uart;
    assign w_cmd_acc    = i_cmd_valid && r_cmd_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_unit_nxt     = r_unit;
        w_gap_nxt      = r_gap_cnt;
        w_pend_nxt     = r_pend;
        w_cmd_full_nxt = r_cmd_full;
        w_cmd_unit_nxt = r_cmd_unit;
        w_rr_nxt       = r_rr_ptr;
        w_cmd_err_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_btn) begin
                    w_unit_nxt  = w_btn_unit;
                    w_pend_nxt  = r_pend & ~w_btn_mask;
                    w_rr_nxt    = SRC_UART;
                    w_state_nxt = ST_ISSUE;
                end else if (w_grant_uart) begin
                    w_unit_nxt     = r_cmd_unit;
                    w_cmd_full_nxt = 1'b0;
                    w_rr_nxt       = SRC_BTN;
                    w_state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (GAP_CYC == 0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = C_GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 8'd1) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Presses are OR-ed in after the grant clear so a same-cycle press survives.
        if (i_set_mode) begin
            w_pend_nxt = w_pend_nxt | {i_btn_hour, i_btn_min, i_btn_sec};
        end else begin
            w_pend_nxt = 3'b000;
        end

        if (w_cmd_acc && i_set_mode) begin
            if (w_dec_invalid) begin
                w_cmd_err_nxt = 1'b1;
            end else begin
                w_cmd_full_nxt = 1'b1;
                w_cmd_unit_nxt = w_dec_unit;
            end
        end

        w_cmd_ready_nxt = !w_cmd_full_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_unit      <= UNIT_NONE;
            r_gap_cnt   <= 8'd0;
            r_pend      <= 3'b000;
            r_cmd_full  <= 1'b0;
            r_cmd_unit  <= UNIT_NONE;
            r_rr_ptr    <= SRC_BTN;
            r_cmd_ready <= 1'b0;
            r_run_sec   <= 1'b0;
            r_run_min   <= 1'b0;
            r_run_hour  <= 1'b0;
            r_clear     <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_unit      <= w_unit_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_pend      <= w_pend_nxt;
            r_cmd_full  <= w_cmd_full_nxt;
            r_cmd_unit  <= w_cmd_unit_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            // Pulses are registered off the ISSUE state, so they trail it by one cycle.
            r_run_sec   <= (r_state == ST_ISSUE) && (r_unit == UNIT_SEC);
            r_run_min   <= (r_state == ST_ISSUE) && (r_unit == UNIT_MIN);
            r_run_hour  <= (r_state == ST_ISSUE) && (r_unit == UNIT_HOUR);
            r_clear     <= (r_state == ST_ISSUE) && (r_unit == UNIT_CLR);
            r_cmd_err   <= w_cmd_err_nxt;
            r_busy      <= (r_state != ST_IDLE);
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_run_sec   = r_run_sec;
    assign o_run_min   = r_run_min;
    assign o_run_hour  = r_run_hour;
    assign o_clear     = r_clear;
    assign o_cmd_err   = r_cmd_err;
    assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_watch_adj_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_watch_adj_sched
// Brief    : Directed bench with a request-level reference model for watch_adj_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_watch_adj_sched;

    localparam int GAP = 3;

    logic       clk;
    logic       rst;
    logic       i_set_mode;
    logic       i_btn_sec;
    logic       i_btn_min;
    logic       i_btn_hour;
    logic       i_cmd_valid;
    logic [7:0] i_cmd_data;
    logic       o_cmd_ready;
    logic       o_run_sec;
    logic       o_run_min;
    logic       o_run_hour;
    logic       o_clear;
    logic       o_cmd_err;
    logic       o_busy;

    watch_adj_sched #(.GAP_CYC(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_set_mode  (i_set_mode),
        .i_btn_sec   (i_btn_sec),
        .i_btn_min   (i_btn_min),
        .i_btn_hour  (i_btn_hour),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_data  (i_cmd_data),
        .o_cmd_ready (o_cmd_ready),
        .o_run_sec   (o_run_sec),
        .o_run_min   (o_run_min),
        .o_run_hour  (o_run_hour),
        .o_clear     (o_clear),
        .o_cmd_err   (o_cmd_err),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output indices: 0 sec, 1 min, 2 hour, 3 clear, 4 err, 5 ready, 6 busy.
    // Unit numbers: 0 none, 1 sec, 2 min, 3 hour, 4 clear.
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit mdl_on    = 1'b0;
    bit pend[3];
    bit slot_full;
    int slot_unit;
    int pref;
    int g         = -1000;
    int g_unit;
    int free_edge;
    int err_cyc   = -1;
    bit ready_exp;

    int lit_c[64];
    int lit_s[64];
    bit lit_v[64];
    int lit_n = 0;

    function automatic int decode_byte(input logic [7:0] b);
        case (b)
            8'h73:   return 1;
            8'h6D:   return 2;
            8'h68:   return 3;
            8'h63:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic string sname(input int i);
        case (i)
            0: return "run_sec";
            1: return "run_min";
            2: return "run_hour";
            3: return "clear";
            4: return "cmd_err";
            5: return "cmd_ready";
            default: return "busy";
        endcase
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    // Reference model: requests, a one-slot UART mailbox and the earliest edge
    // at which a new grant may be taken.
    initial begin : model
        bit acc;
        int btn_u;
        int u;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                pend      = '{0, 0, 0};
                slot_full = 1'b0;
                slot_unit = 0;
                pref      = 0;
                g         = -1000;
                g_unit    = 0;
                free_edge = 0;
                err_cyc   = -1;
                ready_exp = 1'b0;
                mdl_on    = 1'b1;
            end else begin
                acc = i_cmd_valid && ready_exp;
                if (cyc >= free_edge) begin
                    btn_u = pend[2] ? 3 : pend[1] ? 2 : pend[0] ? 1 : 0;
                    if (btn_u != 0 && (!slot_full || pref == 0)) begin
                        g = cyc; g_unit = btn_u; pend[btn_u-1] = 1'b0; pref = 1;
                        free_edge = cyc + GAP + 2;
                    end else if (slot_full) begin
                        g = cyc; g_unit = slot_unit; slot_full = 1'b0; pref = 0;
                        free_edge = cyc + GAP + 2;
                    end
                end
                if (i_set_mode) begin
                    if (i_btn_sec)  pend[0] = 1'b1;
                    if (i_btn_min)  pend[1] = 1'b1;
                    if (i_btn_hour) pend[2] = 1'b1;
                end else begin
                    pend = '{0, 0, 0};
                end
                if (acc && i_set_mode) begin
                    u = decode_byte(i_cmd_data);
                    if (u == 0) err_cyc = cyc;
                    else begin
                        slot_full = 1'b1;
                        slot_unit = u;
                    end
                end
                ready_exp = !slot_full;
            end
        end
    end

    initial begin : compare
        logic [6:0] av;
        logic [6:0] ev;
        forever begin
            @(negedge clk);
            if (mdl_on) begin
                av = {o_busy, o_cmd_ready, o_cmd_err, o_clear, o_run_hour, o_run_min, o_run_sec};
                ev = '0;
                if (cyc == g + 1) ev[g_unit-1] = 1'b1;
                ev[4] = (cyc == err_cyc);
                ev[5] = ready_exp;
                ev[6] = (cyc >= g + 1) && (cyc <= g + 1 + GAP);
                for (int i = 0; i < 7; i++) chk(sname(i), av[i], ev[i]);
                chk("onehot", ($countones(av[3:0]) <= 1), 1'b1);
                for (int k = 0; k < lit_n; k++) begin
                    if (lit_c[k] == cyc) chk({"lit_", sname(lit_s[k])}, av[lit_s[k]], lit_v[k]);
                end
            end
        end
    end

    task automatic add_lit(input int c, input int s, input bit v);
        lit_c[lit_n] = c;
        lit_s[lit_n] = s;
        lit_v[lit_n] = v;
        lit_n++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin : stim
        int b;
        rst = 1'b1; i_set_mode = 1'b0;
        i_btn_sec = 1'b0; i_btn_min = 1'b0; i_btn_hour = 1'b0;
        i_cmd_valid = 1'b0; i_cmd_data = 8'h00;
        add_lit(1, 5, 0); add_lit(1, 6, 0); add_lit(2, 5, 0); add_lit(3, 5, 1);
        wait_to(2);
        rst = 1'b0; i_set_mode = 1'b1;

        // Single minute press sampled at edge 10.
        wait_to(9);
        add_lit(11, 1, 0); add_lit(12, 1, 1); add_lit(13, 1, 0);
        add_lit(11, 6, 0); add_lit(12, 6, 1); add_lit(15, 6, 1); add_lit(16, 6, 0);
        add_lit(12, 0, 0); add_lit(12, 2, 0);
        i_btn_min = 1'b1; tick(); i_btn_min = 1'b0;

        // Three simultaneous presses: hour, min, sec at 5-cycle spacing.
        wait_to(20); b = cyc;
        add_lit(b+3, 2, 1); add_lit(b+4, 2, 0); add_lit(b+3, 1, 0);
        add_lit(b+8, 1, 1); add_lit(b+13, 0, 1);
        i_btn_sec = 1'b1; i_btn_min = 1'b1; i_btn_hour = 1'b1; tick();
        i_btn_sec = 1'b0; i_btn_min = 1'b0; i_btn_hour = 1'b0;

        // Contention between a stream of 'h' bytes and repeated second presses.
        wait_to(40);
        rst = 1'b1; tick(); rst = 1'b0; tick(); b = cyc;
        add_lit(b+3, 0, 1); add_lit(b+8, 2, 1); add_lit(b+13, 0, 1);
        add_lit(b+1, 5, 0); add_lit(b+6, 5, 0); add_lit(b+7, 5, 1); add_lit(b+8, 5, 0);
        for (int k = 0; k < 15; k++) begin
            i_btn_sec   = ((k % 3) == 0) && (k <= 9);
            i_cmd_valid = 1'b1;
            i_cmd_data  = 8'h68;
            tick();
        end
        i_btn_sec = 1'b0; i_cmd_valid = 1'b0;

        // Unknown byte, then a clear command.
        wait_to(b + 25); b = cyc;
        add_lit(b+1, 4, 1); add_lit(b+2, 4, 0); add_lit(b+1, 5, 1);
        add_lit(b+4, 3, 1); add_lit(b+5, 3, 0); add_lit(b+4, 0, 0);
        i_cmd_valid = 1'b1; i_cmd_data = 8'h41; tick();
        i_cmd_data = 8'h63; tick();
        i_cmd_valid = 1'b0;

        // Adjust disabled: presses discarded, byte consumed silently.
        wait_to(b + 15); b = cyc;
        add_lit(b+1, 5, 1); add_lit(b+1, 4, 0); add_lit(b+3, 0, 0); add_lit(b+3, 6, 0);
        i_set_mode = 1'b0;
        i_btn_sec = 1'b1; i_btn_min = 1'b1; i_btn_hour = 1'b1;
        i_cmd_valid = 1'b1; i_cmd_data = 8'h73; tick();
        i_btn_sec = 1'b0; i_btn_min = 1'b0; i_btn_hour = 1'b0; i_cmd_valid = 1'b0;
        wait_to(b + 8);
        i_set_mode = 1'b1; tick();

        // Reset in GAP with an hour press pending.
        b = cyc;
        add_lit(b+3, 0, 1); add_lit(b+4, 6, 0); add_lit(b+4, 5, 0); add_lit(b+4, 0, 0);
        add_lit(b+5, 5, 1); add_lit(b+8, 2, 0); add_lit(b+9, 2, 0);
        i_btn_sec = 1'b1; tick(); i_btn_sec = 1'b0; tick();
        i_btn_hour = 1'b1; tick(); i_btn_hour = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        wait_to(b + 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
